uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable UART receiver: the runtime-programmable successor to the fixed 8-bit receiver in the UART datapath. It deserialises RX_IN using majority-vote oversampling and supports 5..DATA_WIDTH data bits, optional odd/even parity, and 1 or 2 stop bits. It reports parity, stop and break conditions. It sits between the pad-side serial input and the RX synchroniser/FIFO feeding the register file.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame; must be at least 5.
- PRESCALE_WIDTH, 6: width of the Prescale input.
- LEN_WIDTH, 4: width of Data_Len; must be able to hold DATA_WIDTH.

Ports:
- clk  in  1  oversampling clock; one bit period is Prescale cycles.
- rst_n  in  1  asynchronous reset, active low.
- RX_IN  in  1  serial line, asynchronous to clk; idles high.
- Prescale  in  PRESCALE_WIDTH  oversampling ratio. Legal values are even numbers from 4 to 2^PRESCALE_WIDTH−2; behaviour for other values is unspecified.
- Data_Len  in  LEN_WIDTH  number of data bits. Values below 5 are clamped to 5; values above DATA_WIDTH are clamped to DATA_WIDTH.
- Par_En  in  1  parity bit present.
- Par_Typ  in  1  parity type: 0 = even, 1 = odd.
- Stop_Bits  in  1  stop bits per frame: 0 = one, 1 = two.
- P_DATA  out  DATA_WIDTH  last good frame, LSB-aligned, with unused upper bits 0.
- Data_Valid  out  1  one-cycle pulse for a good frame.
- PAR_Err  out  1  one-cycle pulse for a parity error.
- STP_Err  out  1  one-cycle pulse for a stop-bit error.
- Break_Det  out  1  one-cycle pulse for a break condition.

## Operation
- RX_IN passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised line rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when rx_s = 0, go to START with edge_cnt = 0 and latch Prescale, Data_Len, Par_En, Par_Typ and Stop_Bits into shadow registers. Input changes after that point do not affect the frame in progress.
- Bit timing: edge_cnt counts 0..P−1 per bit, where P is the latched Prescale, then wraps to 0 and bit_cnt increments.
- Sampling: rx_s is sampled at edge_cnt = P/2−1, P/2 and P/2+1. The bit value is the majority (2 of 3). A state's decision is made in the cycle edge_cnt = P/2+1.
- START: a majority of 1 is a glitch; return to IDLE at the decision cycle with no outputs. Otherwise stay in START until edge_cnt = P−1, then go to DATA.
- DATA: shift in LSB first until the latched length is reached, then go to PARITY if Par_En is set, else to STOP.
- PARITY: the received bit is compared with the expected bit. Expected = XOR of the data bits for even parity; its inverse for odd parity.
- STOP: one or two stop bits. The frame closes at the decision cycle of the last stop bit, and the FSM returns to IDLE in that same cycle. A falling edge can then start a new frame in the remainder of the stop period.
- Stop error: any stop bit sampling 0.
- Break: all data bits 0, the parity bit (if present) 0, and the first stop bit 0. Break takes precedence over STP_Err and PAR_Err. On break the FSM goes to WAIT_IDLE and waits there until rx_s = 1, then goes to IDLE.
- Close priority: Break_Det, else error pulses, else a good frame.
  - PAR_Err and STP_Err may pulse together.
  - When any error or break is flagged, Data_Valid stays 0 and P_DATA holds its old value.
  - A good frame updates P_DATA and pulses Data_Valid in the same cycle.

## Timing
- Reset values: P_DATA = 0; Data_Valid, PAR_Err, STP_Err and Break_Det = 0; FSM in IDLE; counters 0.
- Reset is asynchronous and is honoured mid-frame. The next frame requires a fresh falling edge after rst_n deasserts.
- Outputs are registered. Pulses assert the cycle after the closing decision cycle and last exactly one cycle.
- Latency: RX_IN falls at cycle t. N is the total bit count (start + data + parity + stop). Result pulses appear at cycle t + 4 + (N−1)·P + P/2.
  - Example: 8N1 with P = 8 gives t+80.
- Back-to-back frames with no idle gap are received without loss.

## Test plan
- 8N1 with P = 8, sending 0xA5: P_DATA = 0xA5 and Data_Valid pulses at t+80. No error pulses.
- 7O2 with P = 16, sending 0x3C with odd parity bit 1: P_DATA = 0x3C and Data_Valid pulses. Then send 7E1 with a wrong parity bit: PAR_Err pulses, no Data_Valid, and P_DATA stays 0x3C.
- 8N2 with second stop bit 0: STP_Err pulses and P_DATA is unchanged.
- Start glitch (RX_IN low for P/2−2 cycles, then high): no output pulses and the FSM is back in IDLE. A valid 0x5A frame that follows is received correctly.
- Break (line held low for 2 frame times, then high): exactly one Break_Det pulse and no Data_Valid. The next frame, 0x81, is received correctly.
- Reset asserted mid-DATA: all outputs are 0 immediately. A subsequent 5-bit frame 0x15 gives P_DATA = 0x15. Back-to-back 0x11, 0x22 with no gap give two Data_Valid pulses exactly N·P cycles apart.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line, frame configuration and result pulses of the configurable UART receiver.
//   master: drives RX_IN and the frame configuration (Prescale, Data_Len, Par_En, Par_Typ, Stop_Bits),
//           observes P_DATA, Data_Valid, PAR_Err, STP_Err, Break_Det.
//   slave:  the receiver side of the same signals.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int LEN_WIDTH      = 4
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic [LEN_WIDTH-1:0]      Data_Len;
    logic                      Par_En;
    logic                      Par_Typ;
    logic                      Stop_Bits;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_Err;
    logic                      STP_Err;
    logic                      Break_Det;

    modport master (
        output RX_IN, Prescale, Data_Len, Par_En, Par_Typ, Stop_Bits,
        input  P_DATA, Data_Valid, PAR_Err, STP_Err, Break_Det
    );

    modport slave (
        input  RX_IN, Prescale, Data_Len, Par_En, Par_Typ, Stop_Bits,
        output P_DATA, Data_Valid, PAR_Err, STP_Err, Break_Det
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with 3-sample majority vote, parity, stop and break reporting.
//   clk   : oversampling clock (Prescale cycles per bit)
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_cfg_if.slave -- RX_IN and frame configuration in; P_DATA and one-cycle
//           Data_Valid / PAR_Err / STP_Err / Break_Det pulses out
module uart_rx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int LEN_WIDTH      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_cfg_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                sync_q;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [LEN_WIDTH-1:0]      bit_q, bit_d;
    logic [1:0]                samp_q, samp_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_q, par_d;
    logic                      serr_q, serr_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic                      pen_q, pen_d;
    logic                      ptyp_q, ptyp_d;
    logic                      stop2_q, stop2_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      dv_q, dv_d;
    logic                      pe_q, pe_d;
    logic                      se_q, se_d;
    logic                      brk_q, brk_d;

    logic                      rx_s;
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      wrap;
    logic                      dec;
    logic                      maj;
    logic [LEN_WIDTH-1:0]      len_c;

    assign rx_s  = sync_q[1];
    assign half  = pre_q >> 1;
    assign wrap  = edge_q == pre_q - PRESCALE_WIDTH'(1);
    assign dec   = edge_q == half + PRESCALE_WIDTH'(1);
    // The third vote is the live line value in the decision cycle itself.
    assign maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign len_c = (bus.Data_Len < LEN_WIDTH'(5)) ? LEN_WIDTH'(5) :
                   (bus.Data_Len > LEN_WIDTH'(DATA_WIDTH)) ? LEN_WIDTH'(DATA_WIDTH) : bus.Data_Len;

    assign bus.P_DATA     = p_data_q;
    assign bus.Data_Valid = dv_q;
    assign bus.PAR_Err    = pe_q;
    assign bus.STP_Err    = se_q;
    assign bus.Break_Det  = brk_q;

    always_comb begin
        state_d  = state_q;
        edge_d   = wrap ? '0 : edge_q + PRESCALE_WIDTH'(1);
        bit_d    = bit_q;
        samp_d   = samp_q;
        data_d   = data_q;
        par_d    = par_q;
        serr_d   = serr_q;
        pre_d    = pre_q;
        len_d    = len_q;
        pen_d    = pen_q;
        ptyp_d   = ptyp_q;
        stop2_d  = stop2_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        pe_d     = 1'b0;
        se_d     = 1'b0;
        brk_d    = 1'b0;
        if (edge_q == half - PRESCALE_WIDTH'(1)) samp_d[0] = rx_s;
        if (edge_q == half) samp_d[1] = rx_s;
        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!rx_s) begin
                    state_d = START;
                    pre_d   = bus.Prescale;
                    len_d   = len_c;
                    pen_d   = bus.Par_En;
                    ptyp_d  = bus.Par_Typ;
                    stop2_d = bus.Stop_Bits;
                    data_d  = '0;
                    par_d   = 1'b0;
                    serr_d  = 1'b0;
                end
            end
            START: begin
                if (dec && maj) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (dec) data_d = data_q | (DATA_WIDTH'(maj) << bit_q);
                if (wrap) begin
                    bit_d   = (bit_q == len_q - LEN_WIDTH'(1)) ? '0 : bit_q + LEN_WIDTH'(1);
                    state_d = (bit_q != len_q - LEN_WIDTH'(1)) ? DATA : pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (dec) par_d = maj;
                if (wrap) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (wrap) bit_d = bit_q + LEN_WIDTH'(1);
                if (dec) begin
                    // par_q stays 0 when parity is disabled, so it never blocks a break.
                    if (bit_q == '0 && !maj && data_q == '0 && !par_q) begin
                        brk_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end else if (bit_q == LEN_WIDTH'(stop2_q)) begin
                        pe_d     = pen_q && (par_q != (^data_q ^ ptyp_q));
                        se_d     = serr_q || !maj;
                        dv_d     = !pe_d && !se_d;
                        p_data_d = dv_d ? data_q : p_data_q;
                        state_d  = IDLE;
                        edge_d   = '0;
                    end else begin
                        serr_d = !maj;
                    end
                end
            end
            WAIT_IDLE: begin
                edge_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            state_q  <= IDLE;
            edge_q   <= '0;
            bit_q    <= '0;
            samp_q   <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            serr_q   <= 1'b0;
            pre_q    <= '0;
            len_q    <= '0;
            pen_q    <= 1'b0;
            ptyp_q   <= 1'b0;
            stop2_q  <= 1'b0;
            p_data_q <= '0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], bus.RX_IN};
            state_q  <= state_d;
            edge_q   <= edge_d;
            bit_q    <= bit_d;
            samp_q   <= samp_d;
            data_q   <= data_d;
            par_q    <= par_d;
            serr_q   <= serr_d;
            pre_q    <= pre_d;
            len_q    <= len_d;
            pen_q    <= pen_d;
            ptyp_q   <= ptyp_d;
            stop2_q  <= stop2_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            se_q     <= se_d;
            brk_q    <= brk_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: table-driven frames plus glitch, break, reset and back-to-back sequences for uart_rx_cfg.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    uart_rx_cfg_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .LEN_WIDTH(4)) bus ();

    uart_rx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .LEN_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_dv = 0, n_pe = 0, n_se = 0, n_brk = 0;
    int pulse_cyc = -1, dv_prev = -1, dv_last = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Data_Valid) begin
                n_dv    <= n_dv + 1;
                dv_prev <= dv_last;
                dv_last <= cyc;
            end
            if (bus.PAR_Err) n_pe <= n_pe + 1;
            if (bus.STP_Err) n_se <= n_se + 1;
            if (bus.Break_Det) n_brk <= n_brk + 1;
            if (bus.Data_Valid || bus.PAR_Err || bus.STP_Err || bus.Break_Det) pulse_cyc <= cyc;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         dlen;
        bit         pen;
        bit         ptyp;
        bit         stop2;
        int         p;
        bit         bad_par;
        bit         bad_stop;
        int         dv;
        int         pe;
        int         se;
        logic [7:0] pdata;
    } vec_t;

    vec_t vecs[7];
    int   t0;
    int   b_dv, b_pe, b_se, b_brk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int eff_len(input int dlen);
        return dlen < 5 ? 5 : dlen > 8 ? 8 : dlen;
    endfunction

    function automatic int latency(input int dlen, input bit pen, input bit stop2, input int p);
        int n;
        n = 1 + eff_len(dlen) + int'(pen) + 1 + int'(stop2);
        return 4 + (n - 1) * p + p / 2;
    endfunction

    task automatic snap();
        b_dv  = n_dv;
        b_pe  = n_pe;
        b_se  = n_se;
        b_brk = n_brk;
    endtask

    task automatic check_counts(input string nm, input int dv, input int pe, input int se, input int brk);
        check({nm, " Data_Valid count"}, n_dv - b_dv, dv);
        check({nm, " PAR_Err count"}, n_pe - b_pe, pe);
        check({nm, " STP_Err count"}, n_se - b_se, se);
        check({nm, " Break_Det count"}, n_brk - b_brk, brk);
    endtask

    task automatic hold(input logic v, input int n);
        bus.RX_IN = v;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; the first bit is sampled by the DUT at posedge t0.
    task automatic send_frame(input logic [7:0] d, input int dlen, input bit pen, input bit ptyp,
                              input bit stop2, input int p, input bit bad_par, input bit bad_stop);
        int  len;
        bit  par;
        len = eff_len(dlen);
        bus.Prescale  = 6'(p);
        bus.Data_Len  = 4'(dlen);
        bus.Par_En    = pen;
        bus.Par_Typ   = ptyp;
        bus.Stop_Bits = stop2;
        t0 = cyc + 1;
        par = ptyp;
        hold(1'b0, p);
        for (int i = 0; i < len; i++) begin
            par ^= d[i];
            hold(d[i], p);
        end
        if (pen) hold(par ^ bad_par, p);
        if (stop2) hold(1'b1, p);
        hold(!bad_stop, p);
        bus.RX_IN = 1'b1;
    endtask

    initial begin
        bus.RX_IN     = 1'b1;
        bus.Prescale  = 6'd8;
        bus.Data_Len  = 4'd8;
        bus.Par_En    = 1'b0;
        bus.Par_Typ   = 1'b0;
        bus.Stop_Bits = 1'b0;

        vecs[0] = '{8'hA5, 8,  1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b0, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h3C, 7,  1'b1, 1'b1, 1'b1, 16, 1'b0, 1'b0, 1, 0, 0, 8'h3C};
        vecs[2] = '{8'h3C, 7,  1'b1, 1'b0, 1'b0, 16, 1'b1, 1'b0, 0, 1, 0, 8'h3C};
        vecs[3] = '{8'h5A, 8,  1'b0, 1'b0, 1'b1, 8,  1'b0, 1'b1, 0, 0, 1, 8'h3C};
        vecs[4] = '{8'h15, 3,  1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b0, 1, 0, 0, 8'h15};
        vecs[5] = '{8'hC3, 15, 1'b1, 1'b0, 1'b0, 6,  1'b0, 1'b0, 1, 0, 0, 8'hC3};
        vecs[6] = '{8'h2A, 6,  1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1, 0, 1, 1, 8'hC3};

        repeat (3) @(negedge clk);
        check("reset P_DATA", int'(bus.P_DATA), 0);
        check("reset Data_Valid", int'(bus.Data_Valid), 0);
        check("reset PAR_Err", int'(bus.PAR_Err), 0);
        check("reset STP_Err", int'(bus.STP_Err), 0);
        check("reset Break_Det", int'(bus.Break_Det), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        foreach (vecs[i]) begin
            snap();
            send_frame(vecs[i].data, vecs[i].dlen, vecs[i].pen, vecs[i].ptyp, vecs[i].stop2,
                       vecs[i].p, vecs[i].bad_par, vecs[i].bad_stop);
            repeat (3 * vecs[i].p) @(negedge clk);
            check_counts($sformatf("vec%0d", i), vecs[i].dv, vecs[i].pe, vecs[i].se, 0);
            check($sformatf("vec%0d P_DATA", i), int'(bus.P_DATA), int'(vecs[i].pdata));
            check($sformatf("vec%0d latency", i), pulse_cyc - t0,
                  latency(vecs[i].dlen, vecs[i].pen, vecs[i].stop2, vecs[i].p));
        end

        // Start glitch shorter than half a bit, then a clean frame.
        snap();
        bus.Prescale = 6'd8;
        hold(1'b0, 2);
        hold(1'b1, 30);
        check_counts("glitch", 0, 0, 0, 0);
        snap();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_counts("after glitch", 1, 0, 0, 0);
        check("after glitch P_DATA", int'(bus.P_DATA), 'h5A);
        check("after glitch latency", pulse_cyc - t0, 80);

        // Break: line low for two frame times.
        snap();
        hold(1'b0, 160);
        hold(1'b1, 20);
        check_counts("break", 0, 0, 0, 1);
        check("break P_DATA held", int'(bus.P_DATA), 'h5A);
        snap();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_counts("after break", 1, 0, 0, 0);
        check("after break P_DATA", int'(bus.P_DATA), 'h81);

        // Reset mid-DATA clears outputs at once.
        hold(1'b0, 8);
        hold(1'b1, 16);
        hold(1'b0, 6);
        rst_n = 1'b0;
        #1;
        check("mid reset P_DATA", int'(bus.P_DATA), 0);
        check("mid reset Data_Valid", int'(bus.Data_Valid), 0);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        snap();
        send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_counts("post reset", 1, 0, 0, 0);
        check("post reset P_DATA", int'(bus.P_DATA), 'h15);

        // Back-to-back frames without an idle gap.
        snap();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_counts("back-to-back", 2, 0, 0, 0);
        check("back-to-back P_DATA", int'(bus.P_DATA), 'h22);
        check("back-to-back spacing", dv_last - dv_prev, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
